// File: rtl/dualport_bus_arbiter.sv
// N-master to 1-slave arbiter for a split read/write bus: independent round-robin
// channels with grant lock and a read-return routing pipe. Optional DPB_ARB_PERF_EN adds handshake counters.
module dualport_bus_arbiter #(
    parameter int N_MST  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
`ifdef DPB_ARB_PERF_EN
    output logic [N_MST*32-1:0]     perf_rd_cnt,
    output logic [N_MST*32-1:0]     perf_wr_cnt,
`endif
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_MST-1:0]        m_rd_req,
    input  logic [N_MST*(DATA_W/8)-1:0] m_rd_be,
    input  logic [N_MST*ADDR_W-1:0] m_rd_addr,
    output logic [N_MST-1:0]        m_rd_gnt,
    output logic [N_MST-1:0]        m_rd_rvalid,
    output logic [DATA_W-1:0]       m_rd_data,
    input  logic [N_MST-1:0]        m_wr_req,
    input  logic [N_MST*(DATA_W/8)-1:0] m_wr_be,
    input  logic [N_MST*ADDR_W-1:0] m_wr_addr,
    input  logic [N_MST*DATA_W-1:0] m_wr_data,
    output logic [N_MST-1:0]        m_wr_gnt,
    output logic                    s_rd_req,
    output logic [DATA_W/8-1:0]     s_rd_be,
    output logic [ADDR_W-1:0]       s_rd_addr,
    input  logic                    s_rd_gnt,
    input  logic [DATA_W-1:0]       s_rd_data,
    output logic                    s_wr_req,
    output logic [DATA_W/8-1:0]     s_wr_be,
    output logic [ADDR_W-1:0]       s_wr_addr,
    output logic [DATA_W-1:0]       s_wr_data,
    input  logic                    s_wr_gnt
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(N_MST);

    typedef enum logic {ST_IDLE, ST_LOCK} ch_state_e;

    // First requester strictly after 'last', wrapping modulo N_MST.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_MST-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_MST; k++) begin
            cand = IDX_W'((int'(last) + k) % N_MST);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    ch_state_e        rd_state_q, rd_state_d;
    logic [IDX_W-1:0] rd_lock_q, rd_lock_d;
    logic [IDX_W-1:0] rd_last_q, rd_last_d;
    logic [IDX_W-1:0] rd_sel;
    logic             rd_sel_vld;
    logic             rd_hs;

    ch_state_e        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] wr_lock_q, wr_lock_d;
    logic [IDX_W-1:0] wr_last_q, wr_last_d;
    logic [IDX_W-1:0] wr_sel;
    logic             wr_sel_vld;
    logic             wr_hs;

    logic [RD_LAT-1:0] ret_vld_q, ret_vld_d;
    logic [IDX_W-1:0]  ret_idx_q [RD_LAT];
    logic [IDX_W-1:0]  ret_idx_d [RD_LAT];

    // Read channel: selection, lock and handshake; all gated off while in reset.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_lock_d  = rd_lock_q;
        rd_last_d  = rd_last_q;
        rd_sel     = rr_pick(m_rd_req, rd_last_q);
        rd_sel_vld = |m_rd_req;
        if (rd_state_q == ST_LOCK) begin
            rd_sel     = rd_lock_q;
            rd_sel_vld = m_rd_req[rd_lock_q];
        end
        rd_sel_vld = rd_sel_vld & rst_n;
        rd_hs      = rd_sel_vld & s_rd_gnt;
        if (rd_hs) begin
            rd_last_d = rd_sel;
        end
        case (rd_state_q)
            ST_IDLE: begin
                if (rd_sel_vld && !s_rd_gnt) begin
                    rd_state_d = ST_LOCK;
                    rd_lock_d  = rd_sel;
                end
            end
            ST_LOCK: begin
                if (rd_hs || !rd_sel_vld) begin
                    rd_state_d = ST_IDLE;
                end
            end
            default: rd_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_lock_d  = wr_lock_q;
        wr_last_d  = wr_last_q;
        wr_sel     = rr_pick(m_wr_req, wr_last_q);
        wr_sel_vld = |m_wr_req;
        if (wr_state_q == ST_LOCK) begin
            wr_sel     = wr_lock_q;
            wr_sel_vld = m_wr_req[wr_lock_q];
        end
        wr_sel_vld = wr_sel_vld & rst_n;
        wr_hs      = wr_sel_vld & s_wr_gnt;
        if (wr_hs) begin
            wr_last_d = wr_sel;
        end
        case (wr_state_q)
            ST_IDLE: begin
                if (wr_sel_vld && !s_wr_gnt) begin
                    wr_state_d = ST_LOCK;
                    wr_lock_d  = wr_sel;
                end
            end
            ST_LOCK: begin
                if (wr_hs || !wr_sel_vld) begin
                    wr_state_d = ST_IDLE;
                end
            end
            default: wr_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_rd_req  = rd_sel_vld;
        s_rd_be   = '0;
        s_rd_addr = '0;
        m_rd_gnt  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (rd_sel_vld && rd_sel == IDX_W'(i)) begin
                s_rd_be     = m_rd_be[i*BE_W +: BE_W];
                s_rd_addr   = m_rd_addr[i*ADDR_W +: ADDR_W];
                m_rd_gnt[i] = s_rd_gnt;
            end
        end
    end

    always_comb begin
        s_wr_req  = wr_sel_vld;
        s_wr_be   = '0;
        s_wr_addr = '0;
        s_wr_data = '0;
        m_wr_gnt  = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (wr_sel_vld && wr_sel == IDX_W'(i)) begin
                s_wr_be     = m_wr_be[i*BE_W +: BE_W];
                s_wr_addr   = m_wr_addr[i*ADDR_W +: ADDR_W];
                s_wr_data   = m_wr_data[i*DATA_W +: DATA_W];
                m_wr_gnt[i] = s_wr_gnt;
            end
        end
    end

    // Return pipe: stage 0 captures the handshake, the last stage drives rvalid.
    always_comb begin
        ret_vld_d[0] = rd_hs;
        ret_idx_d[0] = rd_sel;
        for (int k = 1; k < RD_LAT; k++) begin
            ret_vld_d[k] = ret_vld_q[k-1];
            ret_idx_d[k] = ret_idx_q[k-1];
        end
    end

    always_comb begin
        m_rd_rvalid = '0;
        if (ret_vld_q[RD_LAT-1]) begin
            m_rd_rvalid[ret_idx_q[RD_LAT-1]] = 1'b1;
        end
        m_rd_data = rst_n ? s_rd_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= ST_IDLE;
            rd_lock_q  <= '0;
            rd_last_q  <= IDX_W'(N_MST - 1);
            wr_state_q <= ST_IDLE;
            wr_lock_q  <= '0;
            wr_last_q  <= IDX_W'(N_MST - 1);
            ret_vld_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_lock_q  <= rd_lock_d;
            rd_last_q  <= rd_last_d;
            wr_state_q <= wr_state_d;
            wr_lock_q  <= wr_lock_d;
            wr_last_q  <= wr_last_d;
            ret_vld_q  <= ret_vld_d;
        end
    end

    // Return indices are qualified by ret_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        ret_idx_q <= ret_idx_d;
    end

`ifdef DPB_ARB_PERF_EN
    logic [31:0] perf_rd_q [N_MST];
    logic [31:0] perf_rd_d [N_MST];
    logic [31:0] perf_wr_q [N_MST];
    logic [31:0] perf_wr_d [N_MST];

    always_comb begin
        perf_rd_d = perf_rd_q;
        perf_wr_d = perf_wr_q;
        if (rd_hs) begin
            perf_rd_d[rd_sel] = perf_rd_q[rd_sel] + 32'd1;
        end
        if (wr_hs) begin
            perf_wr_d[wr_sel] = perf_wr_q[wr_sel] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MST; i++) begin
                perf_rd_q[i] <= '0;
                perf_wr_q[i] <= '0;
            end
        end else begin
            perf_rd_q <= perf_rd_d;
            perf_wr_q <= perf_wr_d;
        end
    end

    for (genvar g = 0; g < N_MST; g++) begin : g_perf
        assign perf_rd_cnt[g*32 +: 32] = perf_rd_q[g];
        assign perf_wr_cnt[g*32 +: 32] = perf_wr_q[g];
    end
`endif

endmodule
